holly_bus_router: RTL and testbench

HOLLY_BUS_ROUTER -- requirements
Module: holly_bus_router

---
 rtl/holly_bus_router.sv | 144 ++++++++++++++
 tb/tb_holly_bus_router.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/holly_bus_router.sv
// Holly bus router: decodes a single upstream request onto one of
// NUM_REGIONS address-mapped targets (or a default target), waits for the
// selected target's reply with a timeout, and returns the result upstream.
// One transaction is in flight at a time.
module holly_bus_router #(
  parameter int NUM_REGIONS = 4,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REGIONS*29-1:0]     cfg_base,
  input  logic [NUM_REGIONS*29-1:0]     cfg_limit,
  input  logic [28:0]                   req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_wmask,
  input  logic                          req_wen,
  input  logic                          req_valid,
  output logic                          req_ready,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_valid,
  output logic                          resp_err,
  output logic [28:0]                   dev_addr,
  output logic [DATA_W-1:0]             dev_wdata,
  output logic [DATA_W/8-1:0]           dev_wmask,
  output logic                          dev_wen,
  output logic [NUM_REGIONS-1:0]        dev_req_valid,
  input  logic [NUM_REGIONS-1:0]        dev_resp_valid,
  input  logic [NUM_REGIONS*DATA_W-1:0] dev_resp_rdata,
  output logic                          dflt_req_valid,
  input  logic                          dflt_resp_valid,
  input  logic [DATA_W-1:0]             dflt_resp_rdata,
  output logic [15:0]                   err_count
);

  // Counter value on the last WAIT cycle: the increment would reach TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [NUM_REGIONS-1:0]    hit_oh;
  logic [NUM_REGIONS-1:0]    sel_oh;
  logic                      sel_dflt;
  logic [15:0]               wait_cnt;
  logic                      rsp_hit;
  logic [DATA_W-1:0]         rsp_data;
  logic                      accept;

  assign accept = req_valid && (state == IDLE);

  // Address decode: first (lowest-index) region whose inclusive range holds req_addr
  always_comb begin
    hit_oh = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!(|hit_oh) &&
          (req_addr >= cfg_base[29*i +: 29]) &&
          (req_addr <= cfg_limit[29*i +: 29])) begin
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Response from the latched target only; sel is one-hot so an OR-mux suffices
  always_comb begin
    rsp_hit  = sel_dflt & dflt_resp_valid;
    rsp_data = sel_dflt ? dflt_resp_rdata : '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (sel_oh[i]) begin
        rsp_hit  = rsp_hit | dev_resp_valid[i];
        rsp_data = rsp_data | dev_resp_rdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a response on the final WAIT cycle beats the timeout
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req_valid) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (rsp_hit || (wait_cnt == CNT_LAST)) state_next = RESP;
      RESP:  state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched target select
  always_comb begin
    req_ready      = (state == IDLE);
    resp_valid     = (state == RESP);
    dev_req_valid  = (state == ISSUE) ? sel_oh : '0;
    dflt_req_valid = (state == ISSUE) && sel_dflt;
  end

  // Capture the request and target select on acceptance; held until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_addr  <= '0;
      dev_wdata <= '0;
      dev_wmask <= '0;
      dev_wen   <= 1'b0;
      sel_oh    <= '0;
      sel_dflt  <= 1'b0;
    end else if (accept) begin
      dev_addr  <= req_addr;
      dev_wdata <= req_wdata;
      dev_wmask <= req_wmask;
      dev_wen   <= req_wen;
      sel_oh    <= hit_oh;
      sel_dflt  <= ~|hit_oh;
    end
  end

  // Wait counter, response capture and saturating timeout count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
        if (rsp_hit) begin
          resp_rdata <= rsp_data;
          resp_err   <= 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          resp_rdata <= '1;
          resp_err   <= 1'b1;
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_holly_bus_router.sv
// Bench for holly_bus_router: randomized transactions against a timeline model
// (accept cycle, decoded target, response cycle) plus directed scenarios.
module tb_holly_bus_router;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*29-1:0]  cfg_base, cfg_limit;
  logic [28:0]       req_addr;
  logic [DW-1:0]     req_wdata;
  logic [MW-1:0]     req_wmask;
  logic              req_wen, req_valid, req_ready;
  logic [DW-1:0]     resp_rdata;
  logic              resp_valid, resp_err;
  logic [28:0]       dev_addr;
  logic [DW-1:0]     dev_wdata;
  logic [MW-1:0]     dev_wmask;
  logic              dev_wen;
  logic [NR-1:0]     dev_req_valid, dev_resp_valid;
  logic [NR*DW-1:0]  dev_resp_rdata;
  logic              dflt_req_valid, dflt_resp_valid;
  logic [DW-1:0]     dflt_resp_rdata;
  logic [15:0]       err_count;

  holly_bus_router #(.NUM_REGIONS(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_wen(req_wen), .req_valid(req_valid), .req_ready(req_ready),
    .resp_rdata(resp_rdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wmask(dev_wmask), .dev_wen(dev_wen),
    .dev_req_valid(dev_req_valid), .dev_resp_valid(dev_resp_valid),
    .dev_resp_rdata(dev_resp_rdata), .dflt_req_valid(dflt_req_valid),
    .dflt_resp_valid(dflt_resp_valid), .dflt_resp_rdata(dflt_resp_rdata),
    .err_count(err_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations written by the stimulus process
  bit            active = 1'b0;
  int            exp_a = 0, exp_r = 0, exp_tgt = -1;
  logic          exp_err = 1'b0, exp_wen = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [28:0]   exp_dev_addr = '0;
  logic [DW-1:0] exp_dev_wdata = '0;
  logic [MW-1:0] exp_dev_wmask = '0;
  logic          exp_dev_wen = 1'b0;
  bit            lit_on = 1'b0;
  int            lit_kind = 0;
  logic [63:0]   lit_exp = '0;

  // State owned by the compare process
  logic          hold_err = 1'b0;
  logic [DW-1:0] hold_data = '0;
  bit            hold_known = 1'b1;
  logic [15:0]   model_err = '0;
  int            last_resp_cyc = 0;
  int            n_cmp = 0, n_bad = 0;

  function automatic int find_target(input logic [28:0] addr);
    for (int i = 0; i < NR; i++)
      if (addr >= cfg_base[29*i +: 29] && addr <= cfg_limit[29*i +: 29]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the timeline model
  always @(negedge clk) begin
    bit busy;
    logic [NR-1:0] ev;
    if (rst) begin
      hold_err = 1'b0; hold_data = '0; hold_known = 1'b1; model_err = '0;
    end else if (active && cyc == exp_r) begin
      hold_err   = exp_err;
      hold_data  = exp_data;
      hold_known = exp_err || !exp_wen;
      if (exp_err && model_err != 16'hFFFF) model_err = model_err + 16'd1;
    end
    busy = active && cyc >= exp_a && cyc <= exp_r;
    ev = (active && cyc == exp_a && exp_tgt >= 0) ? (NR'(1) << exp_tgt) : '0;
    chk("req_ready", 64'(req_ready), 64'(!busy));
    chk("dev_req_valid", 64'(dev_req_valid), 64'(ev));
    chk("dflt_req_valid", 64'(dflt_req_valid), 64'(active && cyc == exp_a && exp_tgt < 0));
    chk("resp_valid", 64'(resp_valid), 64'(active && cyc == exp_r));
    chk("resp_err", 64'(resp_err), 64'(hold_err));
    if (hold_known) chk("resp_rdata", resp_rdata, hold_data);
    chk("err_count", 64'(err_count), 64'(model_err));
    chk("dev_addr", 64'(dev_addr), 64'(exp_dev_addr));
    chk("dev_wdata", dev_wdata, exp_dev_wdata);
    chk("dev_wmask", 64'(dev_wmask), 64'(exp_dev_wmask));
    chk("dev_wen", 64'(dev_wen), 64'(exp_dev_wen));
    if (resp_valid) last_resp_cyc = cyc;
    if (lit_on) begin
      case (lit_kind)
        0: chk("lit_latency", 64'(last_resp_cyc - exp_a), lit_exp);
        1: chk("lit_rdata", resp_rdata, lit_exp);
        2: chk("lit_err", 64'(resp_err), lit_exp);
        default: chk("lit_err_count", 64'(err_count), lit_exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input int kind, input logic [63:0] v);
    lit_kind = kind; lit_exp = v; lit_on = 1'b1;
    tick();
    lit_on = 1'b0;
  endtask

  task automatic set_region(input int i, input logic [28:0] b, input logic [28:0] l);
    cfg_base[29*i +: 29]  = b;
    cfg_limit[29*i +: 29] = l;
  endtask

  task automatic randomize_cfg();
    for (int i = 0; i < NR; i++) begin
      logic [28:0] b;
      b = 29'($urandom_range(0, 4000));
      set_region(i, b, ($urandom_range(0, 9) == 0) ? b - 29'd1 : b + 29'($urandom_range(0, 1500)));
    end
  endtask

  // One transaction; lat = WAIT-cycle index of the target reply (>= TO means
  // late/never), rst_at > 0 pulses reset at accept-cycle + rst_at.
  task automatic run_txn(input logic [28:0] addr, input logic wen, input logic [DW-1:0] dat,
                         input int lat, input bit noise, input int rst_at, input bit cfg_swap);
    int guard, tgt, a, last;
    logic [NR-1:0] m;
    guard = 0;
    while (!req_ready && guard < 64) begin tick(); guard++; end
    tgt = find_target(addr);
    req_addr = addr; req_wen = wen; req_wdata = {$urandom, $urandom};
    req_wmask = MW'($urandom); req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a = cyc;
    exp_a = a; exp_tgt = tgt; exp_wen = wen;
    if (lat < TO) begin exp_r = a + 2 + lat; exp_err = 1'b0; exp_data = dat; end
    else          begin exp_r = a + 1 + TO;  exp_err = 1'b1; exp_data = '1;  end
    exp_dev_addr = addr; exp_dev_wdata = req_wdata; exp_dev_wmask = req_wmask; exp_dev_wen = wen;
    active = 1'b1;
    if (cfg_swap) randomize_cfg();
    last = (((a + 1 + lat) > exp_r) ? (a + 1 + lat) : exp_r) + 1;
    for (int c = a; c <= last; c++) begin
      for (int k = 0; k < NR*DW/32; k++) dev_resp_rdata[32*k +: 32] = $urandom;
      dflt_resp_rdata = {$urandom, $urandom};
      m = noise ? NR'($urandom) : '0;
      if (tgt >= 0) m[tgt] = 1'b0;
      dflt_resp_valid = noise && tgt >= 0 && ($urandom_range(0, 1) == 1);
      if (c == a + 1 + lat || (noise && (c == a || c > a + 1 + lat))) begin
        if (tgt >= 0) m[tgt] = 1'b1; else dflt_resp_valid = 1'b1;
        if (c == a + 1 + lat) begin
          if (tgt >= 0) dev_resp_rdata[DW*tgt +: DW] = dat; else dflt_resp_rdata = dat;
        end
      end
      dev_resp_valid = m;
      if (rst_at > 0 && c == a + rst_at) begin
        rst = 1'b1; active = 1'b0;
        exp_dev_addr = '0; exp_dev_wdata = '0; exp_dev_wmask = '0; exp_dev_wen = 1'b0;
        tick();
        rst = 1'b0;
        break;
      end
      tick();
    end
    dev_resp_valid = '0; dflt_resp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] ad;
    int ri;
    cfg_base = '0; cfg_limit = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0; req_wen = 1'b0; req_valid = 1'b0;
    dev_resp_valid = '0; dev_resp_rdata = '0; dflt_resp_valid = 1'b0; dflt_resp_rdata = '0;
    set_region(0, 29'h0C000000, 29'h0C0FFFFF);
    set_region(1, 29'h005F7C00, 29'h005F7CFF);
    set_region(2, 29'h0B000000, 29'h0CFFFFFF);
    set_region(3, 29'h01000000, 29'h010FFFFF);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Read hit in region 1, zero-wait reply
    run_txn(29'h005F7C10, 1'b0, 64'h1122334455667788, 0, 1'b0, 0, 1'b0);
    lit(0, 64'd2);
    lit(1, 64'h1122334455667788);
    lit(2, 64'd0);
    // Overlap (region 0 wins) and miss (default target)
    run_txn(29'h0C000000, 1'b0, {$urandom, $urandom}, 1, 1'b0, 0, 1'b0);
    run_txn(29'h00700000, 1'b0, 64'hDEFA0017CAFE0042, 2, 1'b0, 0, 1'b0);
    lit(1, 64'hDEFA0017CAFE0042);
    // Silent target, late reply 20 cycles after the timeout window
    run_txn(29'h005F7C20, 1'b0, {$urandom, $urandom}, TO + 20, 1'b0, 0, 1'b0);
    lit(1, 64'hFFFFFFFFFFFFFFFF);
    lit(2, 64'd1);
    lit(3, 64'd1);
    // Reply on the exact timeout cycle wins
    run_txn(29'h01000040, 1'b0, 64'h0123456789ABCDEF, TO - 1, 1'b0, 0, 1'b0);
    lit(1, 64'h0123456789ABCDEF);
    lit(2, 64'd0);
    // Limit and limit+1
    run_txn(29'h005F7CFF, 1'b0, {$urandom, $urandom}, 0, 1'b0, 0, 1'b0);
    run_txn(29'h005F7D00, 1'b0, {$urandom, $urandom}, 3, 1'b0, 0, 1'b0);
    // Spurious responses from other targets and a write
    run_txn(29'h0C000100, 1'b0, {$urandom, $urandom}, 4, 1'b1, 0, 1'b0);
    run_txn(29'h01000080, 1'b1, {$urandom, $urandom}, 2, 1'b1, 0, 1'b0);
    // Reset pulse while waiting, then a normal request
    run_txn(29'h005F7C30, 1'b0, {$urandom, $urandom}, 5, 1'b0, 2, 1'b0);
    lit(3, 64'd0);
    lit(1, 64'd0);
    run_txn(29'h005F7C40, 1'b0, 64'h55AA55AA00FF00FF, 0, 1'b0, 0, 1'b0);
    lit(1, 64'h55AA55AA00FF00FF);

    // Randomized traffic, including mid-flight cfg changes and reset pulses
    randomize_cfg();
    for (int t = 0; t < 160; t++) begin
      if (t % 16 == 0) randomize_cfg();
      ri = $urandom_range(0, NR - 1);
      case ($urandom_range(0, 4))
        0: ad = cfg_base[29*ri +: 29];
        1: ad = cfg_limit[29*ri +: 29];
        2: ad = cfg_limit[29*ri +: 29] + 29'd1;
        3: ad = cfg_base[29*ri +: 29] - 29'd1;
        default: ad = 29'($urandom_range(0, 6000));
      endcase
      run_txn(ad, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 11),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0,
              ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) tick();
    end
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
